stack_unit: RTL and testbench
=============================

Name: stack_unit

Overview:
- Parametrised operand stack for the multicycle stack-machine datapath.
- Replaces the fixed 8-bit push/pop/tos stack.
- Adds configurable width and depth, occupancy and full/empty status, simultaneous push+pop (replace top), DUP and SWAP, and sticky overflow/underflow error flags.
- Sits between the stack-input mux (ALU result / MDR) and the A/B operand registers; exposes top-of-stack (TOS) and next-on-stack (NOS).

Parameters:
- WIDTH, 8, data word width in bits
- DEPTH, 16, number of entries; power of two, >= 2
- CNT_W, $clog2(DEPTH)+1, width of the occupancy count

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-low reset
- push  input  1  push din
- pop  input  1  remove TOS
- dup  input  1  push a copy of TOS
- swap  input  1  exchange TOS and NOS
- din  input  WIDTH  data for push/replace
- clr_err  input  1  clear sticky error flags
- tos  output  WIDTH  current top entry; 0 when empty
- nos  output  WIDTH  entry below top; 0 when count < 2
- count  output  CNT_W  occupancy, 0..DEPTH
- empty  output  1  count == 0
- full  output  1  count == DEPTH
- overflow  output  1  sticky; an illegal growth was attempted
- underflow  output  1  sticky; an illegal shrink/read was attempted

Behaviour:
- Clock and reset: one clock, clk; reset is asynchronous and active-low (rst).
- Reset values while rst = 0: count = 0, empty = 1, full = 0, overflow = 0, underflow = 0, tos = 0, nos = 0. Storage contents are don't-care; tos/nos are masked to 0 by count.
- State is the stack pointer (count) plus a DEPTH x WIDTH storage array. Entry count-1 is TOS.
- All operations commit on the rising clk edge.
- tos, nos, count and the flags are combinational from registered state, so they reflect an operation in the cycle after the edge (1-cycle latency). There is no combinational path from command inputs to any output.
- Command decode priority: swap > dup > {push, pop}. Lower-priority commands asserted in the same cycle are ignored, with no error.
- push only:
  - count < DEPTH: write din at entry count; count + 1.
  - full: no state change; overflow set.
- pop only:
  - count > 0: count - 1. Entry contents are left in place.
  - empty: no change; underflow set.
- push and pop together (replace):
  - count > 0: TOS := din; count unchanged. Legal when full.
  - empty: no change; underflow set.
- dup:
  - 0 < count < DEPTH: write TOS at entry count; count + 1.
  - empty: no change; underflow set.
  - full: no change; overflow set.
- swap:
  - count >= 2: entries count-1 and count-2 exchange in one edge.
  - count < 2: no change; underflow set.
- Sticky flags:
  - Set by any illegal operation; cleared by clr_err.
  - If clr_err and a new error occur in the same cycle, the flag is 1 after the edge (set wins).
- No command asserted: state holds.
- Reset asserted mid-operation: state returns to reset values immediately (async). The first operation is accepted on the first rising edge after rst deasserts.
- count never wraps: it saturates logically because illegal operations are blocked.

Decomposition:
- Shared package stack_pkg holds:
  - localparam encodings for the internal decoded operation: OP_NONE, OP_PUSH, OP_POP, OP_REPL, OP_DUP, OP_SWAP
  - default WIDTH/DEPTH constants for the datapath
- One sub-module, stack_ram: DEPTH x WIDTH register array with two write ports (needed for swap) and two read ports (tos, nos). It is written only on legal operations and has no reset on contents.
- Pointer, decode and flag logic stay in stack_unit.

Test Plan:
- Reset, then push 0x11, 0x22, 0x33 -> tos = 0x33, nos = 0x22, count = 3, empty = 0.
- Push DEPTH values 1..16, then push 0xFF -> full = 1, count = 16, tos = 16, overflow = 1. Then clr_err -> overflow = 0.
- From empty, pop, then swap with count = 1 -> underflow = 1 and count unchanged each time. clr_err asserted together with another illegal pop -> underflow stays 1.
- Stack [0x05, 0x09] (TOS 0x09): swap -> tos = 0x05, nos = 0x09. Dup -> count = 3, tos = nos = 0x05. Push+pop with din = 0xA0 -> tos = 0xA0, count = 3.
- Full stack: push+pop with din = 0x7E -> tos = 0x7E, count = DEPTH, no overflow. swap+push asserted together -> only swap executes.
- Assert rst low asynchronously between edges with count = 5 -> count = 0, tos = 0 immediately. After release, push 0x3C -> tos = 0x3C, count = 1.

Source files
------------

// File: rtl/stack_pkg.sv
// Shared constants for the operand stack: decoded operation codes and datapath defaults.
package stack_pkg;

    localparam int unsigned DEF_WIDTH = 8;
    localparam int unsigned DEF_DEPTH = 16;

    typedef logic [2:0] op_t;

    localparam op_t OP_NONE = 3'd0;
    localparam op_t OP_PUSH = 3'd1;
    localparam op_t OP_POP  = 3'd2;
    localparam op_t OP_REPL = 3'd3;
    localparam op_t OP_DUP  = 3'd4;
    localparam op_t OP_SWAP = 3'd5;

endpackage

// File: rtl/stack_if.sv
// Command/status bundle between the stack-input mux, the operand stack and the A/B registers.
interface stack_if
    import stack_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned DEPTH = DEF_DEPTH,
    parameter int unsigned CNT_W = $clog2(DEPTH) + 1
);
    logic             push;
    logic             pop;
    logic             dup;
    logic             swap;
    logic             clr_err;
    logic [WIDTH-1:0] din;
    logic [WIDTH-1:0] tos;
    logic [WIDTH-1:0] nos;
    logic [CNT_W-1:0] count;
    logic             empty;
    logic             full;
    logic             overflow;
    logic             underflow;

    modport master (
        output push, pop, dup, swap, clr_err, din,
        input  tos, nos, count, empty, full, overflow, underflow
    );

    modport slave (
        input  push, pop, dup, swap, clr_err, din,
        output tos, nos, count, empty, full, overflow, underflow
    );
endinterface

// File: rtl/stack_ram.sv
// DEPTH x WIDTH register array, two write ports (swap writes both) and two async read ports.
module stack_ram #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic             clk_i,
    input  logic             we0_i,
    input  logic [AW-1:0]    waddr0_i,
    input  logic [WIDTH-1:0] wdata0_i,
    input  logic             we1_i,
    input  logic [AW-1:0]    waddr1_i,
    input  logic [WIDTH-1:0] wdata1_i,
    input  logic [AW-1:0]    raddr0_i,
    output logic [WIDTH-1:0] rdata0_o,
    input  logic [AW-1:0]    raddr1_i,
    output logic [WIDTH-1:0] rdata1_o
);
    logic [WIDTH-1:0] mem_q [DEPTH];

    // Contents are intentionally unreset; readers mask them with the occupancy count.
    always_ff @(posedge clk_i) begin
        if (we0_i) mem_q[waddr0_i] <= wdata0_i;
        if (we1_i) mem_q[waddr1_i] <= wdata1_i;
    end

    assign rdata0_o = mem_q[raddr0_i];
    assign rdata1_o = mem_q[raddr1_i];
endmodule

// File: rtl/stack_unit.sv
// Operand stack: pointer, command decode and sticky error flags around a two-port register array.
module stack_unit
    import stack_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned DEPTH = DEF_DEPTH,
    parameter int unsigned CNT_W = $clog2(DEPTH) + 1
) (
    input  logic    clk,
    input  logic    rst,
    stack_if.slave  bus
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;
    logic             ovf_set, unf_set;
    op_t              op;

    logic             we0, we1;
    logic [AW-1:0]    waddr0, waddr1;
    logic [WIDTH-1:0] wdata0, wdata1;
    logic [AW-1:0]    tos_idx, nos_idx, top_free;
    logic [WIDTH-1:0] tos_rd, nos_rd;
    logic             is_empty, is_full, lt_two;

    assign is_empty = (cnt_q == '0);
    assign is_full  = (cnt_q == CNT_W'(DEPTH));
    assign lt_two   = (cnt_q < CNT_W'(2));
    assign tos_idx  = AW'(cnt_q - CNT_W'(1));
    assign nos_idx  = AW'(cnt_q - CNT_W'(2));
    assign top_free = AW'(cnt_q);

    always_comb begin
        op = OP_NONE;
        if (bus.swap)                  op = OP_SWAP;
        else if (bus.dup)              op = OP_DUP;
        else if (bus.push && bus.pop)  op = OP_REPL;
        else if (bus.push)             op = OP_PUSH;
        else if (bus.pop)              op = OP_POP;
    end

    always_comb begin
        cnt_d   = cnt_q;
        we0     = 1'b0;
        we1     = 1'b0;
        waddr0  = top_free;
        waddr1  = nos_idx;
        wdata0  = bus.din;
        wdata1  = tos_rd;
        ovf_set = 1'b0;
        unf_set = 1'b0;
        case (op)
            OP_PUSH: begin
                if (is_full) begin
                    ovf_set = 1'b1;
                end else begin
                    we0   = 1'b1;
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            OP_POP: begin
                if (is_empty) unf_set = 1'b1;
                else          cnt_d   = cnt_q - CNT_W'(1);
            end
            OP_REPL: begin
                if (is_empty) begin
                    unf_set = 1'b1;
                end else begin
                    we0    = 1'b1;
                    waddr0 = tos_idx;
                end
            end
            OP_DUP: begin
                if (is_empty) begin
                    unf_set = 1'b1;
                end else if (is_full) begin
                    ovf_set = 1'b1;
                end else begin
                    we0    = 1'b1;
                    wdata0 = tos_rd;
                    cnt_d  = cnt_q + CNT_W'(1);
                end
            end
            OP_SWAP: begin
                if (lt_two) begin
                    unf_set = 1'b1;
                end else begin
                    // Both ports write on the same edge; reads are of pre-edge contents.
                    we0    = 1'b1;
                    waddr0 = tos_idx;
                    wdata0 = nos_rd;
                    we1    = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // A new error in the clearing cycle wins over clr_err.
    assign ovf_d = ovf_set | (ovf_q & ~bus.clr_err);
    assign unf_d = unf_set | (unf_q & ~bus.clr_err);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
            unf_q <= unf_d;
        end
    end

    stack_ram #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk_i    (clk),
        .we0_i    (we0),
        .waddr0_i (waddr0),
        .wdata0_i (wdata0),
        .we1_i    (we1),
        .waddr1_i (waddr1),
        .wdata1_i (wdata1),
        .raddr0_i (tos_idx),
        .rdata0_o (tos_rd),
        .raddr1_i (nos_idx),
        .rdata1_o (nos_rd)
    );

    assign bus.tos       = is_empty ? '0 : tos_rd;
    assign bus.nos       = lt_two ? '0 : nos_rd;
    assign bus.count     = cnt_q;
    assign bus.empty     = is_empty;
    assign bus.full      = is_full;
    assign bus.overflow  = ovf_q;
    assign bus.underflow = unf_q;
endmodule

// File: tb/tb_stack_unit.sv
// Directed vector bench for stack_unit (WIDTH=8, DEPTH=16).
module tb_stack_unit;
    localparam int unsigned W = 8;
    localparam int unsigned D = 16;
    localparam int unsigned C = 5;

    typedef struct {
        logic         push, pop, dup, swap, clr;
        logic [W-1:0] din;
        logic [W-1:0] tos, nos;
        logic [C-1:0] cnt;
        logic         emp, ful, ovf, unf;
    } vec_t;

    logic clk;
    logic rst;
    int   total;
    int   bad;
    vec_t vecs[$];

    stack_if #(.WIDTH(W), .DEPTH(D), .CNT_W(C)) bus ();

    stack_unit #(.WIDTH(W), .DEPTH(D), .CNT_W(C)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input logic p, po, d, s, c, input logic [W-1:0] di,
                                input logic [W-1:0] t, n, input logic [C-1:0] k,
                                input logic e, f, o, u);
        vec_t v;
        v.push = p; v.pop = po; v.dup = d; v.swap = s; v.clr = c; v.din = di;
        v.tos = t; v.nos = n; v.cnt = k; v.emp = e; v.ful = f; v.ovf = o; v.unf = u;
        return v;
    endfunction

    task automatic check(input string nm, input logic [W-1:0] t, n, input logic [C-1:0] k,
                         input logic e, f, o, u);
        logic [2*W+C+3:0] act, exp;
        act = {bus.tos, bus.nos, bus.count, bus.empty, bus.full, bus.overflow, bus.underflow};
        exp = {t, n, k, e, f, o, u};
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got tos=%h nos=%h cnt=%0d e/f/o/u=%b%b%b%b want tos=%h nos=%h cnt=%0d e/f/o/u=%b%b%b%b",
                     nm, bus.tos, bus.nos, bus.count, bus.empty, bus.full, bus.overflow,
                     bus.underflow, t, n, k, e, f, o, u);
        end
    endtask

    task automatic step(input logic p, po, d, s, c, input logic [W-1:0] di);
        bus.push = p; bus.pop = po; bus.dup = d; bus.swap = s; bus.clr_err = c; bus.din = di;
        @(posedge clk);
        #1;
        bus.push = 0; bus.pop = 0; bus.dup = 0; bus.swap = 0; bus.clr_err = 0; bus.din = '0;
    endtask

    task automatic async_reset();
        #3 rst = 1'b0;
        #1;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        bus.push = 0; bus.pop = 0; bus.dup = 0; bus.swap = 0; bus.clr_err = 0; bus.din = '0;
        rst = 1'b0;
        #2 check("reset", 8'h00, 8'h00, 5'd0, 1, 0, 0, 0);
        #10 rst = 1'b1;

        //        p  po d  s  c  din    tos    nos    cnt e  f  o  u
        vecs.push_back(mk(1, 0, 0, 0, 0, 8'h11, 8'h11, 8'h00, 1, 0, 0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0, 0, 8'h22, 8'h22, 8'h11, 2, 0, 0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0, 0, 8'h33, 8'h33, 8'h22, 3, 0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 0, 0, 0, 8'h00, 8'h22, 8'h11, 2, 0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 0, 0, 0, 8'h00, 8'h11, 8'h00, 1, 0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 0, 0, 0, 8'h00, 8'h00, 8'h00, 0, 1, 0, 0, 0));
        vecs.push_back(mk(0, 1, 0, 0, 0, 8'h00, 8'h00, 8'h00, 0, 1, 0, 0, 1));
        vecs.push_back(mk(1, 0, 0, 0, 1, 8'h05, 8'h05, 8'h00, 1, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1, 0, 8'h00, 8'h05, 8'h00, 1, 0, 0, 0, 1));
        vecs.push_back(mk(0, 1, 0, 0, 0, 8'h00, 8'h00, 8'h00, 0, 1, 0, 0, 1));
        vecs.push_back(mk(0, 1, 0, 0, 1, 8'h00, 8'h00, 8'h00, 0, 1, 0, 0, 1));
        vecs.push_back(mk(0, 0, 0, 0, 1, 8'h00, 8'h00, 8'h00, 0, 1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 1, 0, 0, 8'h00, 8'h00, 8'h00, 0, 1, 0, 0, 1));
        vecs.push_back(mk(1, 1, 0, 0, 1, 8'h44, 8'h00, 8'h00, 0, 1, 0, 0, 1));
        vecs.push_back(mk(0, 0, 0, 0, 1, 8'h00, 8'h00, 8'h00, 0, 1, 0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0, 0, 8'h05, 8'h05, 8'h00, 1, 0, 0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0, 0, 8'h09, 8'h09, 8'h05, 2, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1, 0, 8'h00, 8'h05, 8'h09, 2, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 1, 0, 0, 8'h00, 8'h05, 8'h05, 3, 0, 0, 0, 0));
        vecs.push_back(mk(1, 1, 0, 0, 0, 8'hA0, 8'hA0, 8'h05, 3, 0, 0, 0, 0));
        vecs.push_back(mk(1, 0, 1, 1, 0, 8'h77, 8'h05, 8'hA0, 3, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 8'h66, 8'h05, 8'hA0, 3, 0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 1, 0, 0, 8'h00, 8'h05, 8'h05, 4, 0, 0, 0, 0));

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].push, vecs[i].pop, vecs[i].dup, vecs[i].swap, vecs[i].clr, vecs[i].din);
            check($sformatf("vec%0d", i), vecs[i].tos, vecs[i].nos, vecs[i].cnt,
                  vecs[i].emp, vecs[i].ful, vecs[i].ovf, vecs[i].unf);
        end

        // Fill to full from a fresh reset.
        async_reset();
        check("rst_clear", 8'h00, 8'h00, 5'd0, 1, 0, 0, 0);
        #2 rst = 1'b1;
        for (int i = 1; i <= D; i++) begin
            step(1, 0, 0, 0, 0, W'(i));
            check($sformatf("fill%0d", i), W'(i), W'(i - 1), C'(i), 0, (i == D), 0, 0);
        end
        step(1, 0, 0, 0, 0, 8'hFF);
        check("push_full", 8'h10, 8'h0F, 5'd16, 0, 1, 1, 0);
        step(0, 0, 0, 0, 1, 8'h00);
        check("clr_ovf", 8'h10, 8'h0F, 5'd16, 0, 1, 0, 0);
        step(0, 0, 1, 0, 0, 8'h00);
        check("dup_full", 8'h10, 8'h0F, 5'd16, 0, 1, 1, 0);
        step(0, 0, 0, 0, 1, 8'h00);
        step(1, 1, 0, 0, 0, 8'h7E);
        check("repl_full", 8'h7E, 8'h0F, 5'd16, 0, 1, 0, 0);
        step(1, 0, 0, 1, 0, 8'h99);
        check("swap_push", 8'h0F, 8'h7E, 5'd16, 0, 1, 0, 0);
        for (int i = 0; i < 11; i++) step(0, 1, 0, 0, 0, 8'h00);
        check("pop_to5", 8'h05, 8'h04, 5'd5, 0, 0, 0, 0);

        // Async reset between edges, then first op after release.
        async_reset();
        check("async_rst", 8'h00, 8'h00, 5'd0, 1, 0, 0, 0);
        #2 rst = 1'b1;
        step(1, 0, 0, 0, 0, 8'h3C);
        check("post_rst_push", 8'h3C, 8'h00, 5'd1, 0, 0, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
